// File: rtl/med_frame.sv
// med_frame: self-sequenced streaming median over frames of P unsigned samples,
// using a compare-exchange shift network that extracts one maximum per pass.
module med_frame #(
  parameter int W = 8,
  parameter int P = 9
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] DI,
  input  logic         DSI,
  output logic         RDY,
  output logic [W-1:0] DO,
  output logic         DSO,
  output logic         OVF
);
  localparam int LAT = P * (P + 1) / 2;
  localparam int CW = $clog2(LAT);
  localparam int PW = $clog2(P);
  typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [W-1:0] rf_q [P];
  logic [W-1:0] rf_d [P];
  logic [W-1:0] max_q, max_d, do_q, do_d, hi, lo;
  logic rdy_q, dso_q, ovf_q;
  logic take, fin;
  assign RDY = rdy_q;
  assign DO = do_q;
  assign DSO = dso_q;
  assign OVF = ovf_q;
  assign take = DSI && rdy_q;
  assign fin = cnt_q == CW'(LAT - 2);
  assign hi = max_q > rf_q[0] ? max_q : rf_q[0];
  assign lo = max_q > rf_q[0] ? rf_q[0] : max_q;
  // Each pass: one bypass cycle reloads the running max, then P-1 compares
  // keep the max and push the min to the tail; extracted maxima are replaced by 0.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ph_d = ph_q;
    rf_d = rf_q;
    max_d = max_q;
    do_d = do_q;
    case (state_q)
      LOAD: if (take) begin
        if (cnt_q == CW'(P - 1)) begin
          state_d = SORT;
          cnt_d = '0;
          ph_d = PW'(1);
          max_d = rf_q[1];
          for (int i = 0; i < P - 2; i++) rf_d[i] = rf_q[i + 2];
          rf_d[P-2] = DI;
          rf_d[P-1] = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          for (int i = 0; i < P - 1; i++) rf_d[i] = rf_q[i + 1];
          rf_d[P-1] = DI;
        end
      end
      SORT: if (fin) begin
        state_d = DONE;
        cnt_d = '0;
        do_d = hi;
      end else begin
        cnt_d = cnt_q + CW'(1);
        ph_d = ph_q == PW'(P - 1) ? '0 : ph_q + PW'(1);
        max_d = ph_q == '0 ? rf_q[0] : hi;
        for (int i = 0; i < P - 1; i++) rf_d[i] = rf_q[i + 1];
        rf_d[P-1] = ph_q == '0 ? '0 : lo;
      end
      DONE: begin
        state_d = LOAD;
        if (DSI) begin
          cnt_d = CW'(1);
          for (int i = 0; i < P - 1; i++) rf_d[i] = rf_q[i + 1];
          rf_d[P-1] = DI;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= LOAD;
      cnt_q <= '0;
      ph_q <= '0;
      max_q <= '0;
      do_q <= '0;
      rdy_q <= 1'b1;
      dso_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int i = 0; i < P; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      max_q <= max_d;
      do_q <= do_d;
      rf_q <= rf_d;
      rdy_q <= state_d != SORT;
      dso_q <= state_d == DONE;
      ovf_q <= ovf_q | (DSI & ~rdy_q);
    end
  end
endmodule

// File: tb/tb_med_frame.sv
// tb_med_frame: scoreboard bench for med_frame (P=9 main instance, P=3 side instance).
module tb_med_frame;
  localparam int P = 9;
  localparam int LAT = P * (P + 1) / 2;
  localparam int PER = P + LAT - 1;
  typedef logic [7:0] frame_t [P];
  logic CLK = 0, nRST = 1, DSI = 0, DSI3 = 0;
  logic [7:0] DI = '0, DI3 = '0;
  logic RDY, DSO, OVF, RDY3, DSO3, OVF3;
  logic [7:0] DO, DO3;
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic [7:0] sb[$];

  med_frame #(.W(8), .P(9)) dut (.CLK(CLK), .nRST(nRST), .DI(DI), .DSI(DSI),
    .RDY(RDY), .DO(DO), .DSO(DSO), .OVF(OVF));
  med_frame #(.W(8), .P(3)) dut3 (.CLK(CLK), .nRST(nRST), .DI(DI3), .DSI(DSI3),
    .RDY(RDY3), .DO(DO3), .DSO(DSO3), .OVF(OVF3));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] med(input frame_t v);
    frame_t s = v;
    logic [7:0] t;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P - 1 - i; j++)
        if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
    return s[P/2];
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // k is the edge that launches the last sample; it is captured on edge k+1.
  task automatic send_frame(input frame_t v, input bit sparse, output int k);
    for (int i = 0; i < P; i++) begin
      if (sparse) begin DSI = 0; repeat ($urandom_range(0, 3)) tick(); end
      DI = v[i]; DSI = 1; k = cyc; tick();
    end
    DSI = 0;
    sb.push_back(med(v));
  endtask

  task automatic wait_dso(output int t);
    t = -1;
    for (int i = 0; i < 200 && t < 0; i++) begin tick(); if (DSO) t = cyc; end
  endtask

  task automatic rand_frame(output frame_t v);
    for (int i = 0; i < P; i++) v[i] = 8'($urandom);
  endtask

  task automatic test_reset(input bit mid);
    frame_t v;
    int k, t;
    logic [7:0] e;
    if (mid) begin rand_frame(v); send_frame(v, 0, k); repeat (10) tick(); end
    #3 nRST = 0;
    #1;
    n_chk++; if (DO !== 8'd0) begin n_fail++; $display("FAIL reset_do: got %0d want 0", DO); end
    n_chk++; if (DSO !== 1'b0) begin n_fail++; $display("FAIL reset_dso: got %0b want 0", DSO); end
    n_chk++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", OVF); end
    n_chk++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %0b want 1", RDY); end
    sb.delete();
    tick();
    @(negedge CLK) nRST = 1;
    tick();
    rand_frame(v);
    send_frame(v, 0, k);
    wait_dso(t);
    n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL reset_after_lat: got %0d want %0d", t - k, LAT); end
    e = sb.pop_front();
    n_chk++; if (DO !== e) begin n_fail++; $display("FAIL reset_after_do: got %0d want %0d", DO, e); end
  endtask

  task automatic test_single;
    frame_t v = '{3, 200, 7, 7, 255, 0, 15, 100, 8};
    int k, t;
    logic [7:0] e, prev;
    prev = DO;
    send_frame(v, 0, k);
    n_chk++; if (RDY !== 1'b0) begin n_fail++; $display("FAIL single_rdy_sort: got %0b want 0", RDY); end
    repeat (20) tick();
    n_chk++; if (DO !== prev) begin n_fail++; $display("FAIL single_do_hold_sort: got %0d want %0d", DO, prev); end
    wait_dso(t);
    n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL single_lat: got %0d want %0d", t - k, LAT); end
    e = sb.pop_front();
    n_chk++; if (DO !== e) begin n_fail++; $display("FAIL single_do: got %0d want %0d", DO, e); end
    n_chk++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL single_rdy_done: got %0b want 1", RDY); end
    tick();
    n_chk++; if (DSO !== 1'b0) begin n_fail++; $display("FAIL single_dso_pulse: got %0b want 0", DSO); end
    repeat (5) tick();
    n_chk++; if (DO !== e) begin n_fail++; $display("FAIL single_do_hold: got %0d want %0d", DO, e); end
  endtask

  task automatic test_ordered;
    frame_t v;
    int k, t;
    logic [7:0] e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < P; i++) v[i] = f == 0 ? 8'(9 - i) : 8'hFF;
      send_frame(v, 0, k);
      wait_dso(t);
      e = sb.pop_front();
      n_chk++; if (DO !== e) begin n_fail++; $display("FAIL ordered_do[%0d]: got %0d want %0d", f, DO, e); end
      n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL ordered_lat[%0d]: got %0d want %0d", f, t - k, LAT); end
    end
  endtask

  task automatic test_sparse;
    frame_t v;
    int k, t;
    logic [7:0] e;
    for (int f = 0; f < 4; f++) begin
      rand_frame(v);
      if (f == 0) v[3] = v[5];
      send_frame(v, 1, k);
      wait_dso(t);
      e = sb.pop_front();
      n_chk++; if (DO !== e) begin n_fail++; $display("FAIL sparse_do[%0d]: got %0d want %0d", f, DO, e); end
      n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL sparse_lat[%0d]: got %0d want %0d", f, t - k, LAT); end
    end
  endtask

  // Sample slots follow the expected frame period, so the DONE cycle carries sample 0.
  task automatic test_back_to_back;
    frame_t v;
    logic [7:0] stream[$];
    logic [7:0] e;
    int s, n = 0;
    for (int f = 0; f < 3; f++) begin
      rand_frame(v);
      for (int i = 0; i < P; i++) stream.push_back(v[i]);
      sb.push_back(med(v));
    end
    s = cyc;
    for (int d = 0; d < 3 * PER; d++) begin
      if (d % PER < P) begin DSI = 1; DI = stream[(d / PER) * P + d % PER]; end
      else DSI = 0;
      tick();
      if (DSO) begin
        n_chk++; if (cyc - s !== PER * (n + 1)) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d want %0d", n, cyc - s, PER * (n + 1)); end
        e = sb.size() > 0 ? sb.pop_front() : ~DO;
        n_chk++; if (DO !== e) begin n_fail++; $display("FAIL b2b_do[%0d]: got %0d want %0d", n, DO, e); end
        n++;
      end
    end
    DSI = 0;
    n_chk++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", n); end
    n_chk++; if (OVF !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %0b want 0", OVF); end
  endtask

  task automatic test_overflow;
    frame_t v = '{50, 60, 70, 80, 90, 100, 110, 120, 130};
    frame_t w;
    int k, t;
    bit seen = 0;
    logic [7:0] e;
    send_frame(v, 0, k);
    tick(); tick();
    DI = 8'd0; DSI = 1; tick(); DSI = 0;
    n_chk++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", OVF); end
    wait_dso(t);
    n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL ovf_lat: got %0d want %0d", t - k, LAT); end
    e = sb.pop_front();
    n_chk++; if (DO !== e) begin n_fail++; $display("FAIL ovf_do: got %0d want %0d", DO, e); end
    tick();
    rand_frame(w);
    for (int i = 0; i < P - 1; i++) begin DI = w[i]; DSI = 1; tick(); end
    DSI = 0;
    for (int i = 0; i < LAT + 5; i++) begin tick(); if (DSO) seen = 1; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ovf_short_frame_dso: got %0b want 0", seen); end
    n_chk++; if (RDY !== 1'b1) begin n_fail++; $display("FAIL ovf_short_frame_rdy: got %0b want 1", RDY); end
    DI = w[P-1]; DSI = 1; k = cyc; tick(); DSI = 0;
    sb.push_back(med(w));
    wait_dso(t);
    n_chk++; if (t - k !== LAT) begin n_fail++; $display("FAIL ovf_next_lat: got %0d want %0d", t - k, LAT); end
    e = sb.pop_front();
    n_chk++; if (DO !== e) begin n_fail++; $display("FAIL ovf_next_do: got %0d want %0d", DO, e); end
    n_chk++; if (OVF !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b want 1", OVF); end
  endtask

  task automatic test_p3;
    logic [7:0] f3 [3][3] = '{'{1, 1, 2}, '{9, 5, 7}, '{3, 3, 3}};
    logic [7:0] want [3] = '{1, 7, 3};
    int k, t;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 3; i++) begin DI3 = f3[f][i]; DSI3 = 1; k = cyc; tick(); end
      DSI3 = 0;
      t = -1;
      for (int i = 0; i < 40 && t < 0; i++) begin tick(); if (DSO3) t = cyc; end
      n_chk++; if (t - k !== 6) begin n_fail++; $display("FAIL p3_lat[%0d]: got %0d want 6", f, t - k); end
      n_chk++; if (DO3 !== want[f]) begin n_fail++; $display("FAIL p3_do[%0d]: got %0d want %0d", f, DO3, want[f]); end
    end
  endtask

  initial begin
    tick();
    test_reset(0);
    test_single();
    test_ordered();
    test_sparse();
    test_back_to_back();
    test_overflow();
    test_reset(1);
    test_p3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
